cpu_trace_capture: RTL and testbench

CPU_TRACE_CAPTURE -- requirements
Module: cpu_trace_capture

---
 rtl/cpu_trace_capture.sv | 151 +++++++++++++++
 tb/tb_cpu_trace_capture.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trace_capture.sv
// cpu_trace_capture: buffers CPU commit records in a FIFO and presents them on a ready/valid port.
// Optional macro TRACE_DROP_CNT_EN enables the saturating dropped-record counter behind drop_cnt.
module cpu_trace_capture #(
  parameter int DEPTH       = 8,
  parameter int MAX_COMMITS = 10
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        cap_en,
  input  logic        clear,
  input  logic        PCWre,
  input  logic [31:0] PCout,
  input  logic [31:0] instruction,
  input  logic        RegWre,
  input  logic [4:0]  RFSelectorOut,
  input  logic [31:0] writeData,
  output logic        rec_valid,
  input  logic        rec_ready,
  output logic [31:0] rec_pc,
  output logic [31:0] rec_ins,
  output logic        rec_wre,
  output logic [4:0]  rec_rd,
  output logic [31:0] rec_wdata,
  output logic        done,
  output logic        overflow,
  output logic [7:0]  drop_cnt,
  output logic [15:0] commit_cnt
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          RW       = 32 + 32 + 1 + 5 + 32;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam bit          LIMITED  = (MAX_COMMITS != 0);
  localparam logic [15:0] LAST_CNT = 16'(MAX_COMMITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

  state_t        state_reg, state_next;
  logic          commit, last_commit;
  logic          push, pop, drop, full, bypass;
  logic [RW-1:0] wr_data, head_reg;
  logic [RW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   count_reg, count_next;
  logic [15:0]   commit_cnt_reg;
  logic          overflow_reg;

  // FSM: state register
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // FSM: next state; clear overrides everything, including DONE
  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:    if (cap_en) state_next = S_CAPTURE;
        S_CAPTURE: begin
          if (last_commit)  state_next = S_DONE;
          else if (!cap_en) state_next = S_IDLE;
        end
        S_DONE:    state_next = S_DONE;
        default:   state_next = S_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    commit      = (state_reg == S_CAPTURE) && PCWre;
    last_commit = commit && LIMITED && (commit_cnt_reg == LAST_CNT);
    done        = (state_reg == S_DONE);
  end

  assign wr_data     = {PCout, instruction, RegWre, RFSelectorOut, writeData};
  assign full        = (count_reg == FULL_CNT);
  assign rec_valid   = (count_reg != '0);
  assign pop         = rec_valid && rec_ready && !clear;
  assign push        = commit && !clear && (!full || pop);
  assign drop        = commit && !clear && full && !pop;
  assign count_next  = count_reg + (AW + 1)'(push) - (AW + 1)'(pop);
  assign rd_ptr_next = rd_ptr_reg + AW'(pop);
  // The new head is the record being written whenever nothing older remains after the pop.
  assign bypass      = push && ((count_reg == '0) || ((count_reg == (AW + 1)'(1)) && pop));

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Registered head: reloaded from the next read address so rec_* never changes while stalled.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      head_reg <= '0;
    end else if (!clear && (count_next != '0)) begin
      head_reg <= bypass ? wr_data : mem[rd_ptr_next];
    end
  end

  assign {rec_pc, rec_ins, rec_wre, rec_rd, rec_wdata} = head_reg;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      commit_cnt_reg <= '0;
      overflow_reg   <= 1'b0;
    end else if (clear) begin
      commit_cnt_reg <= '0;
      overflow_reg   <= 1'b0;
    end else begin
      if (commit && (commit_cnt_reg != 16'hFFFF)) commit_cnt_reg <= commit_cnt_reg + 16'd1;
      if (drop) overflow_reg <= 1'b1;
    end
  end

  assign commit_cnt = commit_cnt_reg;
  assign overflow   = overflow_reg;

`ifdef TRACE_DROP_CNT_EN
  logic [7:0] drop_cnt_reg;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset)                              drop_cnt_reg <= '0;
    else if (clear)                          drop_cnt_reg <= '0;
    else if (drop && (drop_cnt_reg != 8'hFF)) drop_cnt_reg <= drop_cnt_reg + 8'd1;
  end

  assign drop_cnt = drop_cnt_reg;
`else
  assign drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_cpu_trace_capture.sv
// Scoreboard bench for cpu_trace_capture: a default instance (MAX_COMMITS=10) and an
// unlimited instance (MAX_COMMITS=0) share stimulus; one monitor checks both record streams.
module tb_cpu_trace_capture;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        wre;
    logic [4:0]  rd;
    logic [31:0] wd;
  } rec_t;

`ifdef TRACE_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        Reset, cap_en, clear, PCWre, RegWre, rec_ready;
  logic [31:0] PCout, instruction, writeData;
  logic [4:0]  RFSelectorOut;

  logic        d_valid, d_wre, d_done, d_ovf;
  logic [31:0] d_pc, d_ins, d_wd;
  logic [4:0]  d_rd;
  logic [7:0]  d_drop;
  logic [15:0] d_cnt;

  logic        u_valid, u_wre, u_done, u_ovf;
  logic [31:0] u_pc, u_ins, u_wd;
  logic [4:0]  u_rd;
  logic [7:0]  u_drop;
  logic [15:0] u_cnt;

  int   checks = 0;
  int   errors = 0;
  rec_t q_d[$];
  rec_t q_u[$];

  cpu_trace_capture #(.DEPTH(8), .MAX_COMMITS(10)) dut (
    .CLK(clk), .Reset(Reset), .cap_en(cap_en), .clear(clear), .PCWre(PCWre),
    .PCout(PCout), .instruction(instruction), .RegWre(RegWre),
    .RFSelectorOut(RFSelectorOut), .writeData(writeData),
    .rec_valid(d_valid), .rec_ready(rec_ready), .rec_pc(d_pc), .rec_ins(d_ins),
    .rec_wre(d_wre), .rec_rd(d_rd), .rec_wdata(d_wd), .done(d_done),
    .overflow(d_ovf), .drop_cnt(d_drop), .commit_cnt(d_cnt)
  );

  cpu_trace_capture #(.DEPTH(8), .MAX_COMMITS(0)) dut_u (
    .CLK(clk), .Reset(Reset), .cap_en(cap_en), .clear(clear), .PCWre(PCWre),
    .PCout(PCout), .instruction(instruction), .RegWre(RegWre),
    .RFSelectorOut(RFSelectorOut), .writeData(writeData),
    .rec_valid(u_valid), .rec_ready(rec_ready), .rec_pc(u_pc), .rec_ins(u_ins),
    .rec_wre(u_wre), .rec_rd(u_rd), .rec_wdata(u_wd), .done(u_done),
    .overflow(u_ovf), .drop_cnt(u_drop), .commit_cnt(u_cnt)
  );

  function automatic rec_t mk(input logic [31:0] pc);
    rec_t r;
    r.pc  = pc;
    r.ins = pc ^ 32'hDEAD_0013;
    r.wre = pc[2];
    r.rd  = pc[6:2];
    r.wd  = pc + 32'h0000_1000;
    return r;
  endfunction

  task automatic set_in(input logic [31:0] pc);
    rec_t r;
    r = mk(pc);
    PCout         = r.pc;
    instruction   = r.ins;
    RegWre        = r.wre;
    RFSelectorOut = r.rd;
    writeData     = r.wd;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic expect_both(input logic [31:0] pc);
    q_d.push_back(mk(pc));
    q_u.push_back(mk(pc));
  endtask

  task automatic drain();
    int n = 0;
    while (((q_d.size() != 0) || (q_u.size() != 0)) && (n < 40)) begin
      cyc();
      n++;
    end
    chk("drain_pending_dut", q_d.size(), 0);
    chk("drain_pending_unl", q_u.size(), 0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  // Pops one expected record per accepted handshake on each instance.
  task automatic monitor();
    rec_t a, e;
    forever begin
      @(negedge clk);
      if (d_valid && rec_ready) begin
        a = {d_pc, d_ins, d_wre, d_rd, d_wd};
        checks++;
        if (q_d.size() == 0) begin
          errors++;
          $display("FAIL rec_dut: unexpected record pc=%h, required no record", a.pc);
        end else begin
          e = q_d.pop_front();
          if (a !== e) begin
            errors++;
            $display("FAIL rec_dut: got %h, required %h", a, e);
          end else begin
            $display("dut   record pc=%h rd=%0d wdata=%h", a.pc, a.rd, a.wd);
          end
        end
      end
      if (u_valid && rec_ready) begin
        a = {u_pc, u_ins, u_wre, u_rd, u_wd};
        checks++;
        if (q_u.size() == 0) begin
          errors++;
          $display("FAIL rec_unl: unexpected record pc=%h, required no record", a.pc);
        end else begin
          e = q_u.pop_front();
          if (a !== e) begin
            errors++;
            $display("FAIL rec_unl: got %h, required %h", a, e);
          end else begin
            $display("unl   record pc=%h rd=%0d wdata=%h", a.pc, a.rd, a.wd);
          end
        end
      end
    end
  endtask

  task automatic run_tests();
    // Reset held low for two cycles
    Reset = 1'b0; cap_en = 1'b0; clear = 1'b0; PCWre = 1'b0; rec_ready = 1'b0;
    set_in(32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", d_valid, 0);
    chk("reset_done", d_done, 0);
    chk("reset_overflow", d_ovf, 0);
    chk("reset_drop_cnt", d_drop, 0);
    chk("reset_commit_cnt", d_cnt, 0);
    chk("reset_rec_pc", d_pc, 0);
    Reset = 1'b1;

    // Ten commits with consumer always ready; the tenth enters DONE
    cap_en = 1'b1; rec_ready = 1'b1;
    cyc();
    for (int i = 0; i < 10; i++) begin
      set_in(32'(4 * i)); PCWre = 1'b1;
      expect_both(32'(4 * i));
      cyc();
      if (i == 8) chk("done_before_10th", d_done, 0);
    end
    chk("done_after_10th", d_done, 1);
    chk("commit_cnt_10", d_cnt, 10);

    // PCWre while DONE: no records on the limited instance
    for (int k = 0; k < 3; k++) begin
      set_in(32'(40 + 4 * k)); PCWre = 1'b1;
      q_u.push_back(mk(32'(40 + 4 * k)));
      cyc();
    end
    PCWre = 1'b0;
    drain();
    chk("done_held", d_done, 1);
    chk("commit_cnt_held", d_cnt, 10);
    chk("unl_commit_cnt_13", u_cnt, 13);
    chk("unl_never_done", u_done, 0);
    cap_en = 1'b0;
    pulse_clear();
    chk("clear_done", d_done, 0);
    chk("clear_commit_cnt", d_cnt, 0);
    chk("clear_valid", d_valid, 0);

    // Eleven commits with consumer stalled: eight kept, rest dropped
    rec_ready = 1'b0; cap_en = 1'b1;
    cyc();
    for (int i = 0; i < 11; i++) begin
      set_in(32'(4 * i)); PCWre = 1'b1;
      if (i < 8) expect_both(32'(4 * i));
      cyc();
    end
    PCWre = 1'b0;
    chk("full_valid", d_valid, 1);
    chk("full_head_pc", d_pc, 0);
    chk("full_overflow", d_ovf, 1);
    chk("full_done", d_done, 1);
    chk("full_commit_cnt", d_cnt, 10);
    chk("full_drop_cnt", d_drop, DROP_EN ? 2 : 0);
    chk("unl_full_valid", u_valid, 1);
    chk("unl_overflow", u_ovf, 1);
    chk("unl_drop_cnt", u_drop, DROP_EN ? 3 : 0);
    chk("unl_commit_cnt_11", u_cnt, 11);

    // Push and pop together while full: accepted, no drop
    set_in(32'd44); PCWre = 1'b1; rec_ready = 1'b1;
    q_u.push_back(mk(32'd44));
    cyc();
    PCWre = 1'b0;
    chk("pushpop_drop_cnt", u_drop, DROP_EN ? 3 : 0);
    chk("pushpop_commit_cnt", u_cnt, 12);
    chk("pushpop_head_pc", u_pc, 4);
    chk("pushpop_commit_dut", d_cnt, 10);
    drain();
    chk("drained_valid", u_valid, 0);
    chk("drained_valid_dut", d_valid, 0);
    cap_en = 1'b0;
    pulse_clear();
    chk("clear_overflow", u_ovf, 0);
    chk("clear_drop_cnt", u_drop, 0);
    chk("clear_unl_cnt", u_cnt, 0);

    // cap_en drops with the fourth commit; later PCWre is ignored
    cap_en = 1'b1; rec_ready = 1'b1;
    cyc();
    for (int i = 0; i < 4; i++) begin
      set_in(32'h200 + 32'(4 * i)); PCWre = 1'b1;
      if (i == 3) cap_en = 1'b0;
      expect_both(32'h200 + 32'(4 * i));
      cyc();
    end
    for (int i = 0; i < 5; i++) begin
      set_in(32'h2F0 + 32'(4 * i)); PCWre = 1'b1;
      cyc();
    end
    PCWre = 1'b0;
    drain();
    chk("capoff_commit_cnt", d_cnt, 4);
    chk("capoff_unl_cnt", u_cnt, 4);
    chk("capoff_done", d_done, 0);
    pulse_clear();

    // Asynchronous reset with five records buffered
    cap_en = 1'b1; rec_ready = 1'b0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      set_in(32'h300 + 32'(4 * i)); PCWre = 1'b1;
      cyc();
    end
    PCWre = 1'b0;
    chk("prereset_valid", d_valid, 1);
    chk("prereset_unl_cnt", u_cnt, 5);
    @(negedge clk);
    #2;
    Reset = 1'b0;
    #1;
    chk("async_valid", d_valid, 0);
    chk("async_unl_valid", u_valid, 0);
    chk("async_commit_cnt", d_cnt, 0);
    chk("async_unl_cnt", u_cnt, 0);
    chk("async_rec_pc", d_pc, 0);
    chk("async_done", d_done, 0);

    // After release, first push lands on the second rising edge
    @(posedge clk);
    #1;
    Reset = 1'b1; rec_ready = 1'b1;
    set_in(32'h400); PCWre = 1'b1;
    cyc();
    set_in(32'h404);
    expect_both(32'h404);
    cyc();
    PCWre = 1'b0;
    drain();
    chk("release_commit_cnt", d_cnt, 1);
    chk("release_unl_cnt", u_cnt, 1);
    repeat (2) cyc();
  endtask

  initial begin
    fork
      run_tests();
      monitor();
      begin
        #50000;
        errors++;
        $display("FAIL timeout: stimulus incomplete at 50000 ns, required completion");
      end
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
